// File: rtl/stream_arb_pkg.sv
// Purpose: shared types and limits for the stream round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package stream_arb_pkg;

    // Packet-lock FSM states, used only when STREAM_ARB_LOCK_EN is defined
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int MAX_NUM_REQ = 16;

endpackage

// File: rtl/rr_pick.sv
// Purpose: combinational round-robin first-one finder, searching upward from start_i with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; found_o is low when no request bit is set.
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               found_o
);

    // Walk the requests from start_i, wrapping modulo NUM_REQ; first set bit wins
    always_comb begin
        int cand;
        cand    = 0;
        grant_o = '0;
        found_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(start_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                grant_o = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Purpose: round-robin arbiter sharing one registered valid/ready stream among NUM_REQ requesters
//          (optional packet lock when STREAM_ARB_LOCK_EN is defined).
// Latency: accepted input beat appears on the output one cycle later; one beat per cycle sustained.
// Backpressure: all req_ready_o drop combinationally when the output register is full and out_ready_i=0.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic                          out_last_o,
    output logic [IDX_W-1:0]              out_src_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i
);

`ifdef SIMULATION
    initial begin
        if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ || DATA_WIDTH < 1) begin
            $fatal(1, "stream_rr_arbiter: illegal parameters NUM_REQ=%0d DATA_WIDTH=%0d",
                   NUM_REQ, DATA_WIDTH);
        end
    end
`endif

    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [IDX_W-1:0]      out_src_q, out_src_d;
    logic                  out_valid_q, out_valid_d;

    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;
    logic [IDX_W-1:0]      grant;
    logic                  grant_vld;
    logic                  stage_free;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;
    logic [IDX_W-1:0]      grant_nxt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req_valid_i),
        .start_i (ptr_q),
        .grant_o (pick_idx),
        .found_o (pick_found)
    );

`ifdef STREAM_ARB_LOCK_EN
    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

    // While locked the grant is pinned to the packet owner; other valids are ignored
    always_comb begin
        grant     = pick_idx;
        grant_vld = pick_found;
        if (state_q == LOCKED) begin
            grant     = lock_idx_q;
            grant_vld = req_valid_i[lock_idx_q];
        end
    end
`else
    // Per-beat arbitration: the picker result is used directly
    always_comb begin
        grant     = pick_idx;
        grant_vld = pick_found;
    end
`endif

    assign stage_free = !out_valid_q || out_ready_i;
    assign accept     = stage_free && grant_vld && !rst_i;
    assign grant_nxt  = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);

    // One-hot ready toward the granted requester, plus payload/last mux from it
    always_comb begin
        req_ready_o = '0;
        sel_data    = '0;
        sel_last    = 1'b0;
        for (int g = 0; g < NUM_REQ; g++) begin
            if (IDX_W'(g) == grant) begin
                req_ready_o[g] = accept;
                sel_data       = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
                sel_last       = req_last_i[g];
            end
        end
    end

    // Output register: load on input transfer, drain on output transfer, replace with no bubble
    always_comb begin
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_src_d   = grant;
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef STREAM_ARB_LOCK_EN
    // Pointer and lock FSM: hold the grant across a packet, advance the pointer past it on last
    always_comb begin
        ptr_d      = ptr_q;
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            if (sel_last) begin
                ptr_d   = grant_nxt;
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                state_d    = LOCKED;
                lock_idx_d = grant;
            end
        end
    end

    // Lock state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    // Pointer moves past every accepted beat's source
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = grant_nxt;
        end
    end
`endif

    // Pointer and output stage registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_src_o   = out_src_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Purpose: directed self-checking bench for stream_rr_arbiter (NUM_REQ=4 main instance, NUM_REQ=3 wrap instance).
// Latency: checks one-cycle input-to-output latency and no-bubble throughput.
// Backpressure: checks that ready drops combinationally while the output is held.
module tb_stream_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst;

    logic [127:0] data;
    logic [3:0]   valid;
    logic [3:0]   last;
    logic [3:0]   ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic [1:0]   out_src;
    logic         out_valid;
    logic         out_ready;

    logic [23:0]  b_data;
    logic [2:0]   b_valid;
    logic [2:0]   b_last;
    logic [2:0]   b_ready;
    logic [7:0]   b_out_data;
    logic         b_out_last;
    logic [1:0]   b_out_src;
    logic         b_out_valid;
    logic         b_out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_data_i  (data),
        .req_valid_i (valid),
        .req_last_i  (last),
        .req_ready_o (ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_src_o   (out_src),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    stream_rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) dut3 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_data_i  (b_data),
        .req_valid_i (b_valid),
        .req_last_i  (b_last),
        .req_ready_o (b_ready),
        .out_data_o  (b_out_data),
        .out_last_o  (b_out_last),
        .out_src_o   (b_out_src),
        .out_valid_o (b_out_valid),
        .out_ready_i (b_out_ready)
    );

    function automatic logic [31:0] pay(input int i);
        return 32'hD000_0000 | 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        valid = 4'hF; last = 4'hF; out_ready = 1'b1;
        b_valid = 3'b000; b_last = 3'b111; b_out_ready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h s=%0d l=%b exp 0 0 0 0", out_valid, out_data, out_src, out_last);
        end
        checks++;
        if (ready !== 4'b0000) begin
            errors++;
            $display("FAIL ready_in_reset got %b exp 0000", ready);
        end
        // Mid-stream reset: get a beat from requester 2 into the output first
        valid = 4'b0100;
        rst = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset_beat got v=%b s=%0d exp 1 2", out_valid, out_src);
        end
        valid = 4'b1010;
        rst = 1'b1;
        #1;
        checks++;
        if (ready !== 4'b0000) begin
            errors++;
            $display("FAIL ready_mid_reset got %b exp 0000", ready);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_clear got v=%b d=%h s=%0d exp 0 0 0", out_valid, out_data, out_src);
        end
        #1;
        checks++;
        if (ready !== 4'b0010) begin
            errors++;
            $display("FAIL post_reset_grant got %b exp 0010", ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== pay(1)) begin
            errors++;
            $display("FAIL post_reset_beat got v=%b s=%0d d=%h exp 1 1 %h", out_valid, out_src, out_data, pay(1));
        end
        valid = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        valid = 4'hF; last = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== 2'(k % 4) || out_data !== pay(k % 4)) begin
                errors++;
                $display("FAIL rr_beat%0d got v=%b s=%0d d=%h exp 1 %0d %h",
                         k, out_valid, out_src, out_data, k % 4, pay(k % 4));
            end
        end
        valid = 4'h0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain got v=%b exp 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        valid = 4'b0010; last = 4'hF; out_ready = 1'b1;
        tick();
        valid = 4'b1010;
        #1;
        checks++;
        if (ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_ready_first got %b exp 1000", ready);
        end
        tick();
        checks++;
        if (out_src !== 2'd3 || out_data !== pay(3)) begin
            errors++;
            $display("FAIL wrap_first got s=%0d d=%h exp 3 %h", out_src, out_data, pay(3));
        end
        tick();
        checks++;
        if (out_src !== 2'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_second got s=%0d v=%b exp 1 1", out_src, out_valid);
        end
        valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        valid = 4'b0001; last = 4'hF; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        valid = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== pay(0) || out_src !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold%0d got r=%b v=%b d=%h s=%0d exp 0000 1 %h 0",
                         k, ready, out_valid, out_data, out_src, pay(0));
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_ready got %b exp 0010", ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== pay(1)) begin
            errors++;
            $display("FAIL bp_release_beat got v=%b s=%0d d=%h exp 1 1 %h", out_valid, out_src, out_data, pay(1));
        end
        valid = 4'b0000;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got v=%b exp 0", out_valid);
        end
    endtask

    task automatic test_lock();
        int          n;
        int          beats0;
        logic        r0;
        logic [1:0]  exp_src [5];
        logic        exp_last [5];
`ifdef STREAM_ARB_LOCK_EN
        n = 4;
        exp_src  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        exp_last = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        n = 5;
        exp_src  = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        exp_last = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
        do_reset();
        beats0 = 0;
        valid = 4'b0011; last = 4'b0010; out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1;
            r0 = ready[0];
            tick();
            checks++;
            if (out_src !== exp_src[k] || out_last !== exp_last[k] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL lock_beat%0d got s=%0d l=%b v=%b exp %0d %b 1",
                         k, out_src, out_last, out_valid, exp_src[k], exp_last[k]);
            end
            if (r0) begin
                beats0++;
                last[0] = (beats0 == 2);
                if (beats0 == 3) valid[0] = 1'b0;
            end
        end
        valid = 4'b0000;
        tick();
    endtask

    task automatic test_num_req3();
        b_data = {8'h33, 8'h22, 8'h11};
        b_out_ready = 1'b1;
        b_last = 3'b111;
        do_reset();
        b_valid = 3'b100;
        tick();
        checks++;
        if (b_out_src !== 2'd2 || b_out_data !== 8'h33) begin
            errors++;
            $display("FAIL n3_req2 got s=%0d d=%h exp 2 33", b_out_src, b_out_data);
        end
        b_valid = 3'b011;
        #1;
        checks++;
        if (b_ready !== 3'b001) begin
            errors++;
            $display("FAIL n3_wrap_ready got %b exp 001", b_ready);
        end
        tick();
        checks++;
        if (b_out_src !== 2'd0 || b_out_data !== 8'h11) begin
            errors++;
            $display("FAIL n3_wrap_beat got s=%0d d=%h exp 0 11", b_out_src, b_out_data);
        end
        b_valid = 3'b000;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) data[i*32 +: 32] = pay(i);
        b_data = {8'h33, 8'h22, 8'h11};
        test_reset();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_lock();
        test_num_req3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter that shares one valid/ready output stream among NUM_REQ requesting streams of DATA_WIDTH bits. It sits in front of a shared datapath resource and decides which requester drives it each beat. It has a registered output stage, so the shared resource sees clean registered data, valid, last and source index. It sustains one beat per cycle when the output is not back-pressured.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesters; legal range 2..16.
- DATA_WIDTH, default 32: payload width in bits; must be ≥ 1.
- IDX_W, derived, equal to $clog2(NUM_REQ): width of the source index.

Ports:
- clk_i, input, 1: the only clock; all logic is rising-edge.
- rst_i, input, 1: synchronous, active-high reset.
- req_data_i, input, NUM_REQ×DATA_WIDTH: per-requester payload.
- req_valid_i, input, NUM_REQ: per-requester valid.
- req_last_i, input, NUM_REQ: per-requester end-of-packet marker.
- req_ready_o, output, NUM_REQ: per-requester ready; at most one bit is high per cycle.
- out_data_o, output, DATA_WIDTH: registered payload.
- out_last_o, output, 1: registered last.
- out_src_o, output, IDX_W: index of the requester that supplied the beat.
- out_valid_o, output, 1: registered valid.
- out_ready_i, input, 1: downstream ready.

## Operation
Handshakes:
- A transfer on requester i happens when req_valid_i[i] and req_ready_o[i] are both high.
- An output transfer happens when out_valid_o and out_ready_i are both high.

Output stage:
- The output register accepts a beat when stage_free = !out_valid_o || out_ready_i.
- req_ready_o[g] = stage_free && (g == grant) && req_valid_i[g]. Every other bit is 0.

Grant selection:
- grant is the first requester with valid high, searching from index ptr upward and wrapping modulo NUM_REQ.
- With no valids, no grant is made and req_ready_o is all zero.

Round-robin pointer:
- ptr is IDX_W bits and resets to 0.
- After an accepted beat from g, ptr becomes (g+1) mod NUM_REQ. When NUM_REQ is not a power of 2, it wraps from NUM_REQ-1 to 0.
- With STREAM_ARB_LOCK_EN defined, ptr advances only on an accepted beat that has last set (see Configuration).

Output register:
- On an input transfer it loads data, last and src, and sets out_valid_o.
- On an output transfer with no new input transfer, it clears out_valid_o.
- A simultaneous output and input transfer replaces the contents with no bubble.

Requester rules:
- A requester must not drop req_valid_i or change data while waiting; the arbiter does not check this.
- A requester whose valid drops before it is accepted may lose its turn.

Reset:
- Reset is synchronous and active-high, and may be asserted mid-packet.
- On the next edge: out_valid_o=0, out_data_o=0, out_last_o=0, out_src_o=0, ptr=0, FSM=IDLE.
- Any in-flight beat is discarded and no packet recovery is attempted.
- req_ready_o is 0 for every cycle in which rst_i is high.

## Timing
- Latency: an accepted input beat appears on the output the next cycle.
- Throughput: 1 beat per cycle while out_ready_i stays high.
- Back-pressure: with the output full and out_ready_i=0, all req_ready_o bits are 0 in that same cycle (combinational path from out_ready_i to req_ready_o).
- Fairness without lock: under continuous requests from all requesters, each gets one beat every NUM_REQ accepted beats.
- The pointer and the FSM update on the same edge as the transfer.

## Configuration
The macro is STREAM_ARB_LOCK_EN.

Defined (packet lock):
- FSM with two states, IDLE and LOCKED.
- IDLE → LOCKED on an accepted beat with last=0; lock_idx is set to the granted index.
- In LOCKED, grant is forced to lock_idx and other valids are ignored.
- LOCKED → IDLE on an accepted beat from lock_idx with last=1; ptr becomes (lock_idx+1) mod NUM_REQ.
- A single-beat packet (last=1 in IDLE) stays in IDLE and advances ptr.

Not defined:
- No FSM and no lock_idx register.
- Arbitration happens per beat; last is only passed through.
- Packets from different requesters may interleave.

## Structure
- Package stream_arb_pkg:
  - arb_state_e enum (IDLE, LOCKED).
  - MAX_NUM_REQ = 16.
- Sub-module rr_pick:
  - Combinational round-robin first-one finder.
  - Inputs: req vector, start pointer.
  - Outputs: grant index, grant-found flag.
  - Separately testable.
- Top module stream_rr_arbiter contains the pointer, the optional FSM, the output register and the ready generation.
- Under SIMULATION, an initial check rejects NUM_REQ < 2, NUM_REQ > MAX_NUM_REQ, or DATA_WIDTH < 1.

## Test plan
- Reset mid-stream: rst_i high for 1 cycle while out_valid_o=1 → next cycle out_valid_o=0, out_data_o=0, req_ready_o all zero; the next grant goes to the lowest valid index from 0.
- All four requesters valid, out_ready_i=1, single-beat packets → out_src_o sequence 0,1,2,3,0,… with one beat per cycle and no bubbles.
- Requesters 1 and 3 valid, ptr=2 → requester 3 granted first, then 1; verifies wrap-around.
- Back-pressure: out_ready_i=0 for 5 cycles with the output full → out_data_o held stable and req_ready_o=0 throughout; on release, the next beat follows with no bubble.
- Lock defined: requester 0 sends a 3-beat packet (last on beat 3) while requester 1 is valid → out_src_o=0,0,0, then 1. Lock not defined: out_src_o=0,1,0,1,0 (requester 0 beats interleaved with requester 1).
- NUM_REQ=3: requester 2 accepted → ptr=0, and the next grant goes to requester 0 when requesters 0 and 1 are both valid.
